adc_spi_responder: RTL and testbench

- SPI responder (peripheral end) for the AD7888 SPI master driver.
- Emulates the AD7888 serial interface so the master can be exercised in FPGA loopback and system benches without the physical converter.
- Oversamples the master's CS/SCLK/DIN on a fast system clock, decodes the 8-bit control word, and shifts back a 16-bit frame: 4 leading zeros followed by a 12-bit sample supplied by the upstream data source.

---
 rtl/adc_spi_responder_if.sv | 36 +++
 rtl/adc_spi_responder.sv | 193 +++++++++++++++++++
 tb/tb_adc_spi_responder.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/adc_spi_responder_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : adc_spi_responder_if                                          |
// | Purpose  : SPI pin bundle between the AD7888 master driver and the       |
// |            converter (or its responder model).                           |
// | Signals  : i_spi_cs   - chip select, active low (master -> converter)    |
// |            i_spi_sclk - SPI clock (master -> converter)                  |
// |            i_spi_din  - converter DIN (master -> converter)              |
// |            o_spi_dout - converter DOUT (converter -> master)             |
// |            Directions are named from the converter's point of view.      |
// | Modports : master - drives CS/SCLK/DIN, reads DOUT                       |
// |            slave  - reads CS/SCLK/DIN, drives DOUT                       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface adc_spi_responder_if;
   logic i_spi_cs;
   logic i_spi_sclk;
   logic i_spi_din;
   logic o_spi_dout;

   modport master (
      output i_spi_cs,
      output i_spi_sclk,
      output i_spi_din,
      input  o_spi_dout
   );

   modport slave (
      input  i_spi_cs,
      input  i_spi_sclk,
      input  i_spi_din,
      output o_spi_dout
   );
endinterface
`default_nettype wire

// File: rtl/adc_spi_responder.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : adc_spi_responder                                             |
// | Purpose  : AD7888 serial-interface emulator. Oversamples the master's    |
// |            CS/SCLK/DIN on i_sclk, decodes the 8-bit control word and     |
// |            returns a 16-bit frame {4'b0000, sample[11:0]} MSB first.     |
// | Params   : SYNC_STAGES - synchronizer depth on the SPI pins (2..4)       |
// | Ports    : i_sclk        system clock (rising edge)                      |
// |            i_rst_n       asynchronous active-low reset                   |
// |            spi           SPI pins (slave modport)                        |
// |            i_sample_data 12-bit conversion value for o_channel           |
// |            o_channel     channel under conversion                        |
// |            o_ctrl_word   last complete control word                      |
// |            o_ctrl_valid  pulse when o_ctrl_word updates                  |
// |            o_frame_done  pulse after the 16th SCLK rising edge           |
// |            o_frame_err   pulse when CS rises before 16 rising edges      |
// |            o_busy        frame in progress (CS-fall to CS-rise detect)   |
// |            o_pwrdn       power-down status                               |
// | Macro    : ADC_RESP_PWRDN_EN - when defined, PM1:PM0=11 puts the model   |
// |            into power-down (frames return all zeros) until a control     |
// |            word with another PM value is committed.                      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module adc_spi_responder #(
   parameter int SYNC_STAGES = 2
) (
   input  logic                 i_sclk,
   input  logic                 i_rst_n,
   adc_spi_responder_if.slave   spi,
   input  logic [11:0]          i_sample_data,
   output logic [2:0]           o_channel,
   output logic [7:0]           o_ctrl_word,
   output logic                 o_ctrl_valid,
   output logic                 o_frame_done,
   output logic                 o_frame_err,
   output logic                 o_busy,
   output logic                 o_pwrdn
);

   localparam logic [1:0] c_st_idle      = 2'd0;
   localparam logic [1:0] c_st_shift     = 2'd1;
   localparam logic [1:0] c_st_done_wait = 2'd2;

   // ---------------------------------------------------------------------
   // Input synchronizers, edge-detect delay flops and registered events.
   // The CS chain resets low so a CS already held low when reset releases
   // never looks like a falling edge; a fresh CS rise/fall is required.
   // ---------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] r_cs_sync;
   logic [SYNC_STAGES-1:0] r_sclk_sync;
   logic [SYNC_STAGES-1:0] r_din_sync;
   logic                   r_cs_d;
   logic                   r_sclk_d;
   logic                   r_din_d;
   logic                   r_cs_fall;
   logic                   r_cs_rise;
   logic                   r_sclk_rise;
   logic                   r_sclk_fall;

   always_ff @(posedge i_sclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cs_sync   <= '0;
         r_sclk_sync <= '0;
         r_din_sync  <= '0;
         r_cs_d      <= 1'b0;
         r_sclk_d    <= 1'b0;
         r_din_d     <= 1'b0;
         r_cs_fall   <= 1'b0;
         r_cs_rise   <= 1'b0;
         r_sclk_rise <= 1'b0;
         r_sclk_fall <= 1'b0;
      end else begin
         r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0],   spi.i_spi_cs};
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi.i_spi_sclk};
         r_din_sync  <= {r_din_sync[SYNC_STAGES-2:0],  spi.i_spi_din};
         r_cs_d      <= r_cs_sync[SYNC_STAGES-1];
         r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
         // DIN gets the same delay so it stays aligned with the SCLK events
         r_din_d     <= r_din_sync[SYNC_STAGES-1];
         r_cs_fall   <=  r_cs_d   & ~r_cs_sync[SYNC_STAGES-1];
         r_cs_rise   <= ~r_cs_d   &  r_cs_sync[SYNC_STAGES-1];
         r_sclk_rise <= ~r_sclk_d &  r_sclk_sync[SYNC_STAGES-1];
         r_sclk_fall <=  r_sclk_d & ~r_sclk_sync[SYNC_STAGES-1];
      end
   end

   // ---------------------------------------------------------------------
   // Frame engine
   // ---------------------------------------------------------------------
   logic [1:0]  r_state;
   logic [4:0]  r_bit_cnt;
   logic [15:0] r_tx_shift;
   logic [7:0]  r_rx_shift;
   logic [7:0]  r_ctrl_word;
   logic [2:0]  r_channel;
   logic        r_ctrl_valid;
   logic        r_frame_done;
   logic        r_frame_err;
   logic [15:0] w_load_word;
   logic        w_commit;

   // The 16th rising edge completes the frame; cs_rise in the same cycle wins.
   assign w_commit = (r_state == c_st_shift) && !r_cs_rise && r_sclk_rise &&
                     (r_bit_cnt == 5'd15);

`ifdef ADC_RESP_PWRDN_EN
   logic r_pwrdn;

   always_ff @(posedge i_sclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_pwrdn <= 1'b0;
      end else if (w_commit) begin
         r_pwrdn <= (r_rx_shift[1:0] == 2'b11);
      end
   end

   assign w_load_word = r_pwrdn ? 16'h0000 : {4'b0000, i_sample_data};
   assign o_pwrdn     = r_pwrdn;
`else
   assign w_load_word = {4'b0000, i_sample_data};
   assign o_pwrdn     = 1'b0;
`endif

   always_ff @(posedge i_sclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= c_st_idle;
         r_bit_cnt    <= 5'd0;
         r_tx_shift   <= 16'h0000;
         r_rx_shift   <= 8'h00;
         r_ctrl_word  <= 8'h00;
         r_channel    <= 3'd0;
         r_ctrl_valid <= 1'b0;
         r_frame_done <= 1'b0;
         r_frame_err  <= 1'b0;
      end else begin
         r_ctrl_valid <= w_commit;
         r_frame_done <= w_commit;
         r_frame_err  <= 1'b0;
         // ADD2..0 only takes effect for the following frame (AD7888 pipelining)
         if (w_commit) begin
            r_ctrl_word <= r_rx_shift;
            r_channel   <= r_rx_shift[5:3];
         end
         case (r_state)
            c_st_idle: begin
               if (r_cs_fall) begin
                  r_state    <= c_st_shift;
                  r_tx_shift <= w_load_word;
                  r_bit_cnt  <= 5'd0;
                  r_rx_shift <= 8'h00;
               end
            end
            c_st_shift: begin
               if (r_cs_rise) begin
                  r_state     <= c_st_idle;
                  r_frame_err <= 1'b1;
               end else if (r_sclk_rise) begin
                  // Only the first 8 bits are control; later DIN is don't-care
                  if (r_bit_cnt < 5'd8) begin
                     r_rx_shift <= {r_rx_shift[6:0], r_din_d};
                  end
                  r_bit_cnt <= r_bit_cnt + 5'd1;
                  if (r_bit_cnt == 5'd15) begin
                     r_state <= c_st_done_wait;
                  end
               end else if (r_sclk_fall && (r_bit_cnt != 5'd0)) begin
                  // A falling edge ahead of the first rising edge must not shift
                  r_tx_shift <= {r_tx_shift[14:0], 1'b0};
               end
            end
            c_st_done_wait: begin
               if (r_cs_rise) begin
                  r_state <= c_st_idle;
               end
            end
            default: begin
               r_state <= c_st_idle;
            end
         endcase
      end
   end

   assign spi.o_spi_dout = (r_state == c_st_shift) ? r_tx_shift[15] : 1'b0;
   assign o_busy         = (r_state != c_st_idle);
   assign o_ctrl_word    = r_ctrl_word;
   assign o_channel      = r_channel;
   assign o_ctrl_valid   = r_ctrl_valid;
   assign o_frame_done   = r_frame_done;
   assign o_frame_err    = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_adc_spi_responder.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_adc_spi_responder                                          |
// | Purpose  : Self-checking bench for adc_spi_responder. Acts as the SPI    |
// |            master (SCLK idles high, DIN set on falling edges, DOUT       |
// |            captured on rising edges) and scoreboards returned frames and |
// |            committed control words.                                      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_adc_spi_responder;
   localparam int SYNC_STAGES = 2;
   localparam int HALF        = 10;   // SCLK half period in system clocks

   logic        clk = 1'b0;
   logic        rst_n;
   logic [11:0] sample_data;
   logic [2:0]  channel;
   logic [7:0]  ctrl_word;
   logic        ctrl_valid;
   logic        frame_done;
   logic        frame_err;
   logic        busy;
   logic        pwrdn;

   always #5 clk = ~clk;

   adc_spi_responder_if spi_bus ();

   adc_spi_responder #(.SYNC_STAGES(SYNC_STAGES)) dut (
      .i_sclk        (clk),
      .i_rst_n       (rst_n),
      .spi           (spi_bus),
      .i_sample_data (sample_data),
      .o_channel     (channel),
      .o_ctrl_word   (ctrl_word),
      .o_ctrl_valid  (ctrl_valid),
      .o_frame_done  (frame_done),
      .o_frame_err   (frame_err),
      .o_busy        (busy),
      .o_pwrdn       (pwrdn)
   );

   int n_compared   = 0;
   int n_mismatched = 0;

   // scoreboard state
   logic [15:0] q_frame [$];
   logic [7:0]  q_ctrl  [$];
   int          cnt_valid = 0, cnt_done = 0, cnt_err = 0;
   int          exp_valid = 0, exp_done = 0, exp_err = 0;
   logic [7:0]  exp_word  = 8'h00;
   logic [2:0]  exp_chan  = 3'd0;
   logic        exp_pwrdn = 1'b0;
   logic [7:0]  m_exp;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // pulse monitor: pops the expected control word on every o_ctrl_valid
   always @(negedge clk) begin
      if (frame_done === 1'b1) cnt_done++;
      if (frame_err  === 1'b1) cnt_err++;
      if (ctrl_valid === 1'b1) begin
         cnt_valid++;
         if (q_ctrl.size() == 0) begin
            check("ctrl_valid_unexpected", ctrl_valid, 1'b0);
         end else begin
            m_exp = q_ctrl.pop_front();
            check("ctrl_word_commit", ctrl_word, m_exp);
            check("channel_commit", channel, m_exp[5:3]);
            check("done_with_valid", frame_done, 1'b1);
         end
      end
   end

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic cs_low();
      spi_bus.i_spi_sclk = 1'b1;
      spi_bus.i_spi_cs   = 1'b0;
      wait_clks(HALF);
      // the responder must already have latched the sample by now
      sample_data = ~sample_data;
   endtask

   task automatic clock_bit(input logic din, output logic dout);
      spi_bus.i_spi_sclk = 1'b0;
      spi_bus.i_spi_din  = din;
      wait_clks(HALF);
      dout = spi_bus.o_spi_dout;
      spi_bus.i_spi_sclk = 1'b1;
      wait_clks(HALF);
   endtask

   task automatic run_frame(input logic [7:0] ctrl, input logic [11:0] sample, input int nrise);
      logic [15:0] cap;
      logic [15:0] exp_cap;
      logic        b;
      sample_data = sample;
      if (nrise == 16) begin
         q_frame.push_back(exp_pwrdn ? 16'h0000 : {4'h0, sample});
         q_ctrl.push_back(ctrl);
      end
      cs_low();
      check("busy_in_frame", busy, 1'b1);
      cap = 16'h0000;
      for (int i = 0; i < nrise; i++) begin
         clock_bit((i < 8) ? ctrl[7-i] : 1'b0, b);
         cap = {cap[14:0], b};
      end
      wait_clks(HALF);
      spi_bus.i_spi_cs = 1'b1;
      wait_clks(2*HALF);
      if (nrise == 16) begin
         exp_valid++;
         exp_done++;
         exp_word = ctrl;
         exp_chan = ctrl[5:3];
`ifdef ADC_RESP_PWRDN_EN
         exp_pwrdn = (ctrl[1:0] == 2'b11);
`endif
         if (q_frame.size() == 0) begin
            check("frame_queue_depth", 32'(q_frame.size()), 1);
         end else begin
            exp_cap = q_frame.pop_front();
            check("frame_data", cap, exp_cap);
         end
      end else begin
         exp_err++;
      end
      check("busy_after", busy, 1'b0);
      check("frame_done_cnt", cnt_done, exp_done);
      check("ctrl_valid_cnt", cnt_valid, exp_valid);
      check("frame_err_cnt", cnt_err, exp_err);
      check("ctrl_word", ctrl_word, exp_word);
      check("channel", channel, exp_chan);
      check("pwrdn", pwrdn, exp_pwrdn);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      logic b;
      rst_n              = 1'b0;
      spi_bus.i_spi_cs   = 1'b1;
      spi_bus.i_spi_sclk = 1'b1;
      spi_bus.i_spi_din  = 1'b0;
      sample_data        = 12'h000;
      wait_clks(5);
      check("rst_ctrl_word", ctrl_word, 8'h00);
      check("rst_channel", channel, 3'd0);
      check("rst_busy", busy, 1'b0);
      check("rst_dout", spi_bus.o_spi_dout, 1'b0);
      check("rst_pulses", {ctrl_valid, frame_done, frame_err}, 3'b000);
      check("rst_pwrdn", pwrdn, 1'b0);
      rst_n = 1'b1;
      wait_clks(10);
      check("idle_busy", busy, 1'b0);

      // basic frame, then channel pipelining and once-only sample capture
      run_frame(8'h04, 12'hABC, 16);
      run_frame(8'h2C, 12'h123, 16);
      run_frame(8'h34, 12'h456, 16);

      // early CS rise: nothing committed
      run_frame(8'h04, 12'h111, 9);

      // reset in the middle of a frame with CS held low
      sample_data = 12'h777;
      cs_low();
      for (int i = 0; i < 7; i++) clock_bit(i == 2, b);
      rst_n = 1'b0;
      wait_clks(3);
      exp_word = 8'h00;
      exp_chan = 3'd0;
      exp_pwrdn = 1'b0;
      check("midrst_ctrl_word", ctrl_word, exp_word);
      check("midrst_channel", channel, exp_chan);
      check("midrst_busy", busy, 1'b0);
      check("midrst_dout", spi_bus.o_spi_dout, 1'b0);
      rst_n = 1'b1;
      for (int i = 0; i < 16; i++) begin
         clock_bit(1'b1, b);
         check("postrst_dout", b, 1'b0);
      end
      check("postrst_busy", busy, 1'b0);
      check("postrst_done_cnt", cnt_done, exp_done);
      check("postrst_valid_cnt", cnt_valid, exp_valid);
      spi_bus.i_spi_cs = 1'b1;
      wait_clks(2*HALF);
      run_frame(8'h2C, 12'h5A5, 16);

      // power-down control
      run_frame(8'h07, 12'h321, 16);
      run_frame(8'h04, 12'hFFF, 16);
      run_frame(8'h04, 12'hFFF, 16);

      check("ctrl_queue_empty", 32'(q_ctrl.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end
endmodule
`default_nettype wire
